imem_loader: RTL



---
 rtl/loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/byte_pair_assembler.sv | 22 ++
 rtl/imem_loader.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the imem_loader byte-stream program loader.
package loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM,
    ST_DONE
  } loader_state_t;

  localparam logic [7:0]  LOADER_SYNC_DEFAULT = 8'hA5;
  localparam int unsigned LOADER_HDR_BYTES    = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Stream-in, instruction-memory write port and core status signals of the loader.
// master = loader side, slave = stream source / memory / core side.
interface imem_loader_if;
  // Stream handshake: a byte transfers on a rising edge where in_valid and in_ready are both high.
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        write_enable;
  logic [31:0] write_addr;
  logic [15:0] write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  modport master (
    input  in_data, in_valid,
    output in_ready, write_enable, write_addr, write_data, cpu_hold, load_done, load_err
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, write_enable, write_addr, write_data, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/byte_pair_assembler.sv
// Big-endian byte pair assembler: holds the high byte, presents {hi, current byte}.
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_load_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] word_o
);

  logic [7:0] hi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
    end else if (hi_load_i) begin
      hi_q <= byte_i;
    end
  end

  assign word_o = {hi_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader into the instruction memory write port.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader import loader_pkg::*; #(
  parameter int unsigned N    = 6,
  parameter logic [7:0]  SYNC = LOADER_SYNC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.master bus,
  output loader_state_t state_dbg_o
);

  localparam logic [31:0] DEPTH = 32'd1 << N;

  loader_state_t state_q;
  logic [15:0]   start_q, count_q, index_q, waddr_q, wdata_q;
  logic          we_q, hold_q, done_q, err_q, ready_q;

  logic          accept, hi_load, cur_oob;
  logic [15:0]   pair_word, cur_addr, index_nx;

  assign accept   = bus.in_valid && ready_q;
  assign hi_load  = accept && (state_q == ST_ADDR_HI || state_q == ST_CNT_HI ||
                               state_q == ST_DATA_HI);
  assign cur_addr = start_q + index_q;
  assign index_nx = index_q + 16'd1;
  assign cur_oob  = {16'd0, cur_addr} >= DEPTH;

  byte_pair_assembler u_pair (
    .clk       (clk),
    .rst       (rst),
    .hi_load_i (hi_load),
    .byte_i    (bus.in_data),
    .word_o    (pair_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR over header and data bytes; the sync byte restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (accept && state_q == ST_IDLE) begin
      csum_q <= '0;
    end else if (accept && (state_q == ST_ADDR_HI || state_q == ST_ADDR_LO ||
                            state_q == ST_CNT_HI  || state_q == ST_CNT_LO  ||
                            state_q == ST_DATA_HI || state_q == ST_DATA_LO)) begin
      csum_q <= csum_q ^ bus.in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      count_q <= '0;
      index_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept && bus.in_data == SYNC) begin
            state_q <= ST_ADDR_HI;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        ST_ADDR_HI: if (accept) state_q <= ST_ADDR_LO;
        ST_ADDR_LO: if (accept) begin
          start_q <= pair_word;
          state_q <= ST_CNT_HI;
        end
        ST_CNT_HI: if (accept) state_q <= ST_CNT_LO;
        ST_CNT_LO: if (accept) begin
          count_q <= pair_word;
          index_q <= '0;
          if (pair_word != 16'd0) begin
            state_q <= ST_DATA_HI;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q <= ST_CSUM;
`else
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b0;
`endif
          end
        end
        ST_DATA_HI: if (accept) state_q <= ST_DATA_LO;
        ST_DATA_LO: if (accept) begin
          // Out-of-range words are dropped but the frame keeps parsing.
          if (cur_oob) begin
            err_q <= 1'b1;
          end else begin
            we_q    <= 1'b1;
            waddr_q <= cur_addr;
            wdata_q <= pair_word;
          end
          index_q <= index_nx;
          if (index_nx == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q <= ST_CSUM;
`else
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b0;
`endif
          end else begin
            state_q <= ST_DATA_HI;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: if (accept) begin
          if (bus.in_data != csum_q) err_q <= 1'b1;
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          ready_q <= 1'b0;
        end
`endif
        ST_DONE: begin
          state_q <= ST_IDLE;
          hold_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = ready_q;
  assign bus.write_enable = we_q;
  assign bus.write_addr   = {16'd0, waddr_q};
  assign bus.write_data   = wdata_q;
  assign bus.cpu_hold     = hold_q;
  assign bus.load_done    = done_q;
  assign bus.load_err     = err_q;
  assign state_dbg_o      = state_q;

endmodule
